// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below IO_BASE plus an I/O window holding a
// TX FIFO (valid/ready drain), a STATUS register and an overflow counter.
module dmem_responder #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IoValid,
  output logic [31:0] IoData,
  input  logic        IoReady
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [29:0]   TX_W     = IO_BASE[31:2];
  localparam logic [29:0]   ST_W     = IO_BASE[31:2] + 30'd1;
  localparam logic [29:0]   CLR_W    = IO_BASE[31:2] + 30'd2;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   ram  [DEPTH];
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    ovf;

  logic [29:0] addr_w;
  logic        is_ram, is_tx, is_st, is_clr;
  logic        full, empty, pop, push_req, push, drop, ovf_clr;
  logic [31:0] status_word;

  // Word-granular decode; IO_BASE is 16-byte aligned so the low bits never matter.
  assign addr_w = ALUResult[31:2];
  assign is_ram = (ALUResult < IO_BASE);
  assign is_tx  = (addr_w == TX_W);
  assign is_st  = (addr_w == ST_W);
  assign is_clr = (addr_w == CLR_W);

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign IoValid  = ~empty;
  assign IoData   = fifo[rd_ptr];
  assign pop      = IoValid & IoReady;
  assign push_req = MemWrite & is_tx;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & ~push;
  assign ovf_clr  = MemWrite & is_clr;

  assign status_word = {8'h00, ovf, 6'h00, empty, full, 8'(count)};

  always_comb begin
    ReadData = '0;
    if (is_ram) begin
      ReadData = ram[ALUResult[AW+1:2]];
    end else if (is_st) begin
      ReadData = status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite && is_ram) begin
      ram[ALUResult[AW+1:2]] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_clr) begin
        ovf <= '0;
      end else if (drop && (ovf != 8'hFF)) begin
        ovf <= ovf + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table for the basic RAM / FIFO /
// STATUS flow plus hand-written sequences for full-FIFO, reset and overflow cases.
module tb_dmem_responder;

  localparam logic [31:0] TX  = 32'h0000_1000;
  localparam logic [31:0] ST  = 32'h0000_1004;
  localparam logic [31:0] CLR = 32'h0000_1008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IoValid;
  logic [31:0] IoData;
  logic        IoReady;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic        chk_d;
    logic [31:0] exp_d;
    string       name;
  } vec_t;

  vec_t vt[$];

  dmem_responder #(
    .DEPTH(64),
    .FIFO_DEPTH(4),
    .IO_BASE(32'h0000_1000)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .IoValid(IoValid),
    .IoData(IoData),
    .IoReady(IoReady)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wd;
    IoReady   = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: drive, check combinational view at mid-cycle, commit at next edge.
  task automatic step(input vec_t v);
    drive(v.we, v.addr, v.wd, v.rdy);
    #4;
    if (v.chk_rd) chk({v.name, "/rd"}, ReadData, v.exp_rd);
    chk({v.name, "/valid"}, {31'd0, IoValid}, {31'd0, v.exp_v});
    if (v.chk_d) chk({v.name, "/data"}, IoData, v.exp_d);
    tick();
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic rdy, input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_v, input logic chk_d, input logic [31:0] exp_d,
                              input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_v = exp_v;
    v.chk_d = chk_d; v.exp_d = exp_d; v.name = name;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, ST, 32'h0, 1'b0);
    #2;
    chk("reset/valid", {31'd0, IoValid}, 32'd0);
    chk("reset/status", ReadData, 32'h0000_0200);
    tick();
    tick();
    rst_n = 1'b1;

    // RAM, decode, STATUS and basic FIFO fill / overflow / drain
    vt.push_back(mk(1, 32'h10,  32'hDEAD_BEEF, 0, 0, 0,            0, 0, 0,     "ram_wr"));
    vt.push_back(mk(0, 32'h10,  0,             0, 1, 32'hDEADBEEF, 0, 0, 0,     "ram_rd"));
    vt.push_back(mk(0, 32'h110, 0,             0, 1, 32'hDEADBEEF, 0, 0, 0,     "ram_alias"));
    vt.push_back(mk(0, TX,      0,             0, 1, 32'h0,        0, 0, 0,     "tx_load"));
    vt.push_back(mk(0, 32'h100C,0,             0, 1, 32'h0,        0, 0, 0,     "unmapped"));
    vt.push_back(mk(1, ST,      32'hFFFF_FFFF, 0, 1, 32'h200,      0, 0, 0,     "st_store"));
    vt.push_back(mk(0, ST,      0,             0, 1, 32'h200,      0, 0, 0,     "st_kept"));
    vt.push_back(mk(1, TX,      32'h11,        0, 1, 32'h0,        0, 0, 0,     "push1"));
    vt.push_back(mk(1, TX,      32'h22,        0, 1, 32'h0,        1, 1, 32'h11, "push2"));
    vt.push_back(mk(1, TX,      32'h33,        0, 1, 32'h0,        1, 1, 32'h11, "push3"));
    vt.push_back(mk(1, TX,      32'h44,        0, 1, 32'h0,        1, 1, 32'h11, "push4"));
    vt.push_back(mk(0, ST,      0,             0, 1, 32'h104,      1, 1, 32'h11, "st_full"));
    vt.push_back(mk(1, TX,      32'h55,        0, 1, 32'h0,        1, 1, 32'h11, "push5"));
    vt.push_back(mk(0, ST,      0,             0, 1, 32'h1_0104,   1, 1, 32'h11, "st_ovf1"));
    vt.push_back(mk(0, ST,      0,             1, 1, 32'h1_0104,   1, 1, 32'h11, "pop1"));
    vt.push_back(mk(0, ST,      0,             1, 1, 32'h1_0003,   1, 1, 32'h22, "pop2"));
    vt.push_back(mk(0, ST,      0,             1, 1, 32'h1_0002,   1, 1, 32'h33, "pop3"));
    vt.push_back(mk(0, ST,      0,             1, 1, 32'h1_0001,   1, 1, 32'h44, "pop4"));
    vt.push_back(mk(0, ST,      0,             0, 1, 32'h1_0200,   0, 0, 0,     "drained"));
    vt.push_back(mk(1, CLR,     32'h5A5A,      0, 1, 32'h0,        0, 0, 0,     "ovfclr"));
    vt.push_back(mk(0, ST,      0,             0, 1, 32'h200,      0, 0, 0,     "st_clr"));

    foreach (vt[i]) step(vt[i]);

    // Full FIFO: a push in the same cycle as a pop is accepted
    for (int i = 0; i < 4; i++)
      step(mk(1, TX, 32'hA1 + i, 0, 1, 0, (i > 0), (i > 0), 32'hA1, "fill"));
    step(mk(1, TX, 32'h66, 1, 1, 0,       1, 1, 32'hA1, "full_pushpop"));
    step(mk(0, ST, 0,      0, 1, 32'h104, 1, 1, 32'hA2, "full_kept"));
    step(mk(0, ST, 0,      1, 1, 32'h104, 1, 1, 32'hA2, "drain_a2"));
    step(mk(0, ST, 0,      1, 1, 32'h003, 1, 1, 32'hA3, "drain_a3"));
    step(mk(0, ST, 0,      1, 1, 32'h002, 1, 1, 32'hA4, "drain_a4"));
    step(mk(0, ST, 0,      1, 1, 32'h001, 1, 1, 32'h66, "drain_66"));
    step(mk(0, ST, 0,      0, 1, 32'h200, 0, 0, 0,      "drain_end"));

    // Reset mid-stream clears the FIFO immediately and leaves RAM alone
    step(mk(1, 32'h20, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0,       "ram_wr2"));
    step(mk(1, TX,     32'h77,        0, 1, 0, 0, 0, 0,       "rst_push1"));
    step(mk(1, TX,     32'h88,        0, 1, 0, 1, 1, 32'h77,  "rst_push2"));
    drive(1'b0, ST, 32'h0, 1'b0);
    #2;
    chk("pre_rst/status", ReadData, 32'h002);
    rst_n = 1'b0;
    #1;
    chk("rst/valid", {31'd0, IoValid}, 32'd0);
    chk("rst/status", ReadData, 32'h200);
    ALUResult = 32'h20;
    #1;
    chk("rst/ram20", ReadData, 32'hCAFE_F00D);
    ALUResult = 32'h10;
    #1;
    chk("rst/ram10", ReadData, 32'hDEAD_BEEF);
    tick();
    rst_n = 1'b1;
    step(mk(0, ST, 0, 0, 1, 32'h200, 0, 0, 0, "post_rst"));

    // Overflow counter saturates at 0xFF and clears on OVFCLR
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, TX, 32'hB0 + i, 1'b0);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, TX, 32'hEE, 1'b0);
      tick();
    end
    step(mk(0, ST,  0,       0, 1, 32'h00FF_0104, 1, 1, 32'hB0, "ovf_sat"));
    step(mk(1, CLR, 32'h1234,0, 1, 32'h0,         1, 1, 32'hB0, "ovf_clr"));
    step(mk(0, ST,  0,       0, 1, 32'h0000_0104, 1, 1, 32'hB0, "ovf_zero"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined ARM core's data port: it answers the core's Memory-stage load/store traffic from an internal word RAM and a small memory-mapped I/O window. The I/O window holds a transmit FIFO that posts core stores to an external peripheral through a valid/ready handshake, plus status and overflow registers. It sits beside the core in the top level, on the opposite side of MemWrite/ALUResult/WriteData/ReadData.

## Interface

Parameters:
- DEPTH, 64: RAM size in 32-bit words; power of two.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, 2..16.
- IO_BASE, 32'h0000_1000: byte address of the I/O window; 16-byte aligned.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from the core's Memory stage.
- ALUResult  in  32  byte address; bits [1:0] ignored (word access only).
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from ALUResult.
- IoValid  out  1  TX FIFO head is valid.
- IoData  out  32  TX FIFO head word.
- IoReady  in  1  peripheral accepts the head this cycle.

## Operation

Address decode:
- ALUResult < IO_BASE selects RAM.
  - Word index = ALUResult[log2(DEPTH)+1:2]; higher bits are ignored, so the RAM aliases modulo DEPTH.
- IO_BASE+0 is TXDATA.
  - Store: push WriteData into the FIFO.
  - Load: returns 0.
- IO_BASE+4 is STATUS (read-only; stores ignored).
  - [7:0] = count.
  - [8] = full.
  - [9] = empty.
  - [23:16] = ovf.
  - All other bits 0.
- IO_BASE+8 is OVFCLR.
  - Store of any value: ovf <= 0.
  - Load: returns 0.
- Any other address ≥ IO_BASE: loads return 0, stores are ignored.

RAM:
- A store writes the word at the clock edge.
- Loads are combinational.
- Contents are not reset.

TX FIFO:
- Circular buffer with rd_ptr, wr_ptr and a count register (width log2(FIFO_DEPTH)+1).
- Pointers wrap modulo FIFO_DEPTH.
- IoValid = (count != 0); IoData = mem[rd_ptr].
- pop = IoValid & IoReady.
- push_req = MemWrite & (address is TXDATA).
- push = push_req & (count < FIFO_DEPTH | pop). When full, a push is accepted in the same cycle as a pop.
- count_next = count + push - pop.
- push_req & ~push is a drop: the word is discarded and ovf increments, saturating at 8'hFF.
  - A drop in the same cycle as an OVFCLR store is impossible, since each cycle carries a single address.
  - OVFCLR takes effect only on its own cycle.
- Push and pop together when empty is impossible, because pop requires IoValid.

Reset (asynchronous assert, synchronous-to-clk deassert at the system level):
- count = 0, rd_ptr = wr_ptr = 0, ovf = 0.
- Therefore IoValid = 0 and STATUS reads 0x200.
- IoData is don't-care while IoValid = 0.
- Reset mid-operation discards FIFO contents immediately and does not alter RAM.

## Timing

- Load latency: 0 cycles. ReadData is valid in the same cycle as ALUResult, so the core registers it into the Writeback stage.
- Store-to-load: a RAM store at edge N is visible to a load issued in cycle N+1. There is no same-cycle bypass, because the core never loads and stores in one cycle.
- STATUS loads return register state from before the current edge.
- A push at edge N raises IoValid in cycle N+1.
- A pop at edge N advances IoData in cycle N+1. If count reaches 0, IoValid drops in cycle N+1.
- IoData must stay stable while IoValid = 1 and IoReady = 0.
- Peripheral throughput: one word per cycle when IoReady is held high.

## Test plan

- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 the next cycle → ReadData = 0xDEADBEEF. Load 0x10 + 4*DEPTH → same value (alias).
- With IoReady = 0, store 0x11, 0x22, 0x33, 0x44, 0x55 to TXDATA → STATUS = 0x0000_0104 after 4 stores, then 0x0001_0104 after the 5th (ovf = 1). Raise IoReady → IoData sequence 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then IoValid = 0.
- With the FIFO full and IoReady = 1, store 0x66 to TXDATA in the same cycle → pop accepted, push accepted, count stays 4, ovf unchanged, and 0x66 emerges last.
- Store to OVFCLR after 300 drops → STATUS[23:16] reads 0xFF before the clear and 0x00 after it.
- Push 2 words, assert reset low mid-stream → IoValid = 0 immediately and STATUS = 0x200. A RAM word written before reset still reads back unchanged.
- Load IO_BASE+12 and IO_BASE+0 → ReadData = 0. Store to IO_BASE+4 → STATUS unchanged.
